// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one FP add/sub unit with start/done handshake and timeout abort.
module fp_add_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_err,
  output logic                  add_start,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_sub,
  input  logic                  add_done,
  input  logic [WIDTH-1:0]      add_result,
  output logic                  busy
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RELEASE, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, last_q, last_d, gnt_idx, cand;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic sub_q, sub_d, err_q, err_d, start_q, start_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    gnt_idx = last_q;
    cand = last_q;
    hit = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt_idx = cand;
        hit = 1'b1;
      end
    end
  end
  assign req_ready   = (state_q == IDLE && hit) ? NREQ'(1) << gnt_idx : '0;
  assign resp_valid  = (state_q == RESP) ? NREQ'(1) << g_q : '0;
  assign resp_result = res_q;
  assign resp_err    = err_q;
  assign add_start   = start_q;
  assign add_a       = a_q;
  assign add_b       = b_q;
  assign add_sub     = sub_q;
  assign busy        = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    last_d = last_q;
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    res_d = res_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = START;
        g_d = gnt_idx;
        last_d = gnt_idx;
        a_d = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_d = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        sub_d = req_sub[gnt_idx];
      end
      START: begin
        cnt_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // START already held add_start for one cycle, so abort one count early
        if (add_done) begin
          res_d = add_result;
          err_d = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 2)) begin
          res_d = '0;
          err_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = add_done ? RELEASE : RESP;
      RESP: state_d = resp_ready[g_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    start_d = state_d == START || state_d == WAIT_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      last_q <= GW'(NREQ - 1);
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      last_q <= last_d;
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      res_q <= res_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
    end
  end
endmodule
